rr_arbiter_n: RTL and testbench

Parametrised round-robin arbiter for N requesters with a per-grant hold quantum and a lock input. It replaces the fixed 4-way round-robin arbiter in the design. A grant may be held for several consecutive cycles, and the rotation pointer is kept across idle periods. It sits in front of a shared resource (bus, memory port, output channel) and drives a registered one-hot grant plus an encoded owner index.

---
 rtl/rr_arbiter_n.sv | 104 ++++++++++
 tb/tb_rr_arbiter_n.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters with a per-owner hold quantum and a
// lock input. Grant, owner index and valid are all registered; the rotation
// pointer survives idle periods so priority resumes after the last owner.
module rr_arbiter_n #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 1,
  localparam int IW      = $clog2(N),
  localparam int CW      = $clog2(HOLD_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  REQ,
  input  logic          LOCK,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] GNT_ID,
  output logic          GNT_VLD
);

  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          gnt_vld_q, gnt_vld_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_own;
  logic          req_oth;
  logic          keep;
  logic          win_fnd;
  logic [IW-1:0] win_id;
  logic [IW-1:0] cand;

  // Owner status: gnt_q is one-hot on the owner, so masking with it splits
  // the request vector into "owner" and "everyone else".
  always_comb begin
    req_own = |(REQ & gnt_q);
    req_oth = |(REQ & ~gnt_q);
    keep    = gnt_vld_q && req_own &&
              (LOCK || (cnt_q < CW'(HOLD_MAX)) || !req_oth);
  end

  // Winner search starting just after the last owner; the last owner itself
  // is examined last. Candidate index wraps explicitly so odd N never yields
  // an index >= N.
  always_comb begin
    win_fnd = 1'b0;
    win_id  = '0;
    cand    = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (cand == IW'(N - 1)) cand = '0;
      else                    cand = cand + IW'(1);
      if (!win_fnd && REQ[cand]) begin
        win_fnd = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Next-state decision: KEEP, ROTATE or IDLE.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    gnt_vld_d = gnt_vld_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (keep) begin
      if (cnt_q != CW'(HOLD_MAX)) cnt_d = cnt_q + CW'(1);
    end else if (win_fnd) begin
      gnt_d     = '0;
      gnt_d[win_id] = 1'b1;
      gnt_id_d  = win_id;
      gnt_vld_d = 1'b1;
      cnt_d     = CW'(1);
      ptr_d     = win_id;
    end else begin
      gnt_d     = '0;
      gnt_id_d  = '0;
      gnt_vld_d = 1'b0;
      cnt_d     = '0;
    end
  end

  // State registers with synchronous reset; ptr resets to N-1 so requester 0
  // is first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= IW'(N - 1);
      cnt_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign GNT_ID  = gnt_id_q;
  assign GNT_VLD = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: three instances cover the plain rotation
// case (N=4, HOLD_MAX=1), the quantum/lock case (N=4, HOLD_MAX=3) and odd N.
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] req_a, gnt_a;
  logic [1:0] id_a;
  logic       lock_a, vld_a;

  logic [3:0] req_b, gnt_b;
  logic [1:0] id_b;
  logic       lock_b, vld_b;

  logic [4:0] req_c, gnt_c;
  logic [2:0] id_c;
  logic       lock_c, vld_c;

  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(.N(4), .HOLD_MAX(1)) u_dut_a (
    .clk(clk), .rst(rst), .REQ(req_a), .LOCK(lock_a),
    .GNT(gnt_a), .GNT_ID(id_a), .GNT_VLD(vld_a));

  rr_arbiter_n #(.N(4), .HOLD_MAX(3)) u_dut_b (
    .clk(clk), .rst(rst), .REQ(req_b), .LOCK(lock_b),
    .GNT(gnt_b), .GNT_ID(id_b), .GNT_VLD(vld_b));

  rr_arbiter_n #(.N(5), .HOLD_MAX(1)) u_dut_c (
    .clk(clk), .rst(rst), .REQ(req_c), .LOCK(lock_c),
    .GNT(gnt_c), .GNT_ID(id_c), .GNT_VLD(vld_c));

  task automatic chk_val(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input int id);
    chk_val({tag, "_gnt"}, 32'(gnt_a), 32'(g));
    chk_val({tag, "_id"},  32'(id_a),  32'(id));
    chk_val({tag, "_vld"}, 32'(vld_a), 32'(g != 0));
  endtask

  task automatic chk_b(input string tag, input logic [3:0] g, input int id);
    chk_val({tag, "_gnt"}, 32'(gnt_b), 32'(g));
    chk_val({tag, "_id"},  32'(id_b),  32'(id));
    chk_val({tag, "_vld"}, 32'(vld_b), 32'(g != 0));
  endtask

  logic [3:0] rot_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int         rot_id [5] = '{0, 1, 2, 3, 0};
  logic [3:0] qnt_g  [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
                             4'b0100, 4'b0001};
  int         qnt_id [7] = '{0, 0, 0, 2, 2, 2, 0};

  initial begin
    rst = 1'b1;
    req_a = '0; lock_a = 1'b0;
    req_b = '0; lock_b = 1'b0;
    req_c = '0; lock_c = 1'b0;

    // Reset
    step();
    step();
    chk_a("rst_a", 4'b0000, 0);
    chk_b("rst_b", 4'b0000, 0);
    chk_val("rst_c_gnt", 32'(gnt_c), 32'd0);
    rst = 1'b0;

    // Rotation with HOLD_MAX = 1
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a($sformatf("rot%0d", i), rot_g[i], rot_id[i]);
    end
    req_a = 4'b0000;
    step();
    chk_a("idle_a", 4'b0000, 0);

    // Quantum with HOLD_MAX = 3
    req_b = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      step();
      chk_b($sformatf("qnt%0d", i), qnt_g[i], qnt_id[i]);
    end

    // Sole requester holds indefinitely
    req_b = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0 || i == 9) chk_b($sformatf("sole%0d", i), 4'b0010, 1);
    end
    // LOCK keeps owner despite pending requester 3
    req_b = 4'b1010;
    lock_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_b($sformatf("lock%0d", i), 4'b0010, 1);
    end
    // LOCK falls with cnt saturated: rotate at once
    lock_b = 1'b0;
    step();
    chk_b("unlock", 4'b1000, 3);

    // Early release: owner 2 drops mid-quantum
    req_b = 4'b0100;
    step();
    chk_b("own2", 4'b0100, 2);
    req_b = 4'b0101;
    step();
    chk_b("own2_hold", 4'b0100, 2);
    req_b = 4'b0001;
    step();
    chk_b("early_rel", 4'b0001, 0);
    req_b = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_b($sformatf("idle_b%0d", i), 4'b0000, 0);
    end
    req_b = 4'b1111;
    step();
    chk_b("ptr_keep", 4'b0010, 1);
    req_b = 4'b0000;

    // Odd N = 5
    req_c = 5'b10001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_val($sformatf("odd%0d_gnt", i), 32'(gnt_c),
              (i % 2 == 0) ? 32'h01 : 32'h10);
      chk_val($sformatf("odd%0d_id", i), 32'(id_c),
              (i % 2 == 0) ? 32'd0 : 32'd4);
      chk_val($sformatf("odd%0d_idlt5", i), 32'(id_c < 3'd5), 32'd1);
    end
    req_c = '0;

    // Reset during a locked grant
    req_a = 4'b0011;
    lock_a = 1'b1;
    step();
    chk_a("lk_a0", 4'b0010, 1);
    step();
    chk_a("lk_a1", 4'b0010, 1);
    rst = 1'b1;
    step();
    chk_a("mid_rst", 4'b0000, 0);
    rst = 1'b0;
    lock_a = 1'b0;
    req_a = 4'b1100;
    step();
    chk_a("post_rst", 4'b0100, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
